// File: rtl/rect_fill_pkg.sv
// Shared types, default screen geometry and rectangle normalise/clip helper
// for rect_fill_engine and its raster scan counter.
package rect_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // Helper arithmetic is done at a fixed width wide enough for any COORD_W
  // the engine is built with, so one function serves every instance.
  localparam int PKG_COORD_W = 16;
  typedef logic [PKG_COORD_W-1:0] pcoord_t;

  typedef struct packed {
    pcoord_t xmin;
    pcoord_t xmax;
    pcoord_t ymin;
    pcoord_t ymax;
    logic    xmax_vis;
    logic    ymax_vis;
    logic    empty;
  } rect_t;

  // Normalise the corners and clip the far edges to the screen. The *_vis
  // flags record whether the original far edge lies on-screen.
  function automatic rect_t clip_rect(input pcoord_t x0, input pcoord_t y0,
                                      input pcoord_t x1, input pcoord_t y1,
                                      input pcoord_t sw, input pcoord_t sh);
    rect_t r;
    r.xmin     = (x0 < x1) ? x0 : x1;
    r.xmax     = (x0 < x1) ? x1 : x0;
    r.ymin     = (y0 < y1) ? y0 : y1;
    r.ymax     = (y0 < y1) ? y1 : y0;
    r.xmax_vis = (r.xmax < sw);
    r.ymax_vis = (r.ymax < sh);
    if (!r.xmax_vis) r.xmax = sw - pcoord_t'(1);
    if (!r.ymax_vis) r.ymax = sh - pcoord_t'(1);
    r.empty    = (r.xmin >= sw) || (r.ymin >= sh);
    return r;
  endfunction

endpackage

// File: rtl/rect_fill_engine_raster_scan_counter.sv
// raster_scan_counter: X/Y raster walker with loadable bounds, advance on
// handshake, optional interior skipping for outlines, and a last-pixel flag.
module raster_scan_counter #(
  parameter int COORD_W  = 10,
  parameter int ADDR_W   = 19,
  parameter int SCREEN_W = 640
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load,
  input  logic [COORD_W-1:0] ld_xmin,
  input  logic [COORD_W-1:0] ld_xmax,
  input  logic [COORD_W-1:0] ld_ymin,
  input  logic [COORD_W-1:0] ld_ymax,
  input  logic               ld_skip,
  input  logic               ld_xmax_vis,
  input  logic               ld_ymax_vis,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic [COORD_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic               skip_r, xmax_vis_r, ymax_vis_r;
  logic [ADDR_W-1:0]  row_base;
  logic               full_row;
  logic [COORD_W-1:0] row_end;

  // In outline mode only the top edge and an on-screen bottom edge are full
  // rows; other rows hold xmin plus xmax when the right edge is on-screen.
  assign full_row = !skip_r || (y == ymin_r) || ((y == ymax_r) && ymax_vis_r);
  assign row_end  = (full_row || xmax_vis_r) ? xmax_r : xmin_r;
  assign last     = (y == ymax_r) && (x == row_end);
  assign addr     = row_base + ADDR_W'(x);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      xmin_r     <= '0;
      xmax_r     <= '0;
      ymin_r     <= '0;
      ymax_r     <= '0;
      skip_r     <= 1'b0;
      xmax_vis_r <= 1'b0;
      ymax_vis_r <= 1'b0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
    end else if (load) begin
      xmin_r     <= ld_xmin;
      xmax_r     <= ld_xmax;
      ymin_r     <= ld_ymin;
      ymax_r     <= ld_ymax;
      skip_r     <= ld_skip;
      xmax_vis_r <= ld_xmax_vis;
      ymax_vis_r <= ld_ymax_vis;
      x          <= ld_xmin;
      y          <= ld_ymin;
      row_base   <= ADDR_W'(ld_ymin) * ADDR_W'(SCREEN_W);
    end else if (advance) begin
      if (x == row_end) begin
        x        <= xmin_r;
        y        <= y + COORD_W'(1);
        row_base <= row_base + ADDR_W'(SCREEN_W);
      end else if (!full_row && (x == xmin_r)) begin
        x <= xmax_r;
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: streams full-screen clears and clipped rectangle fills as
// a valid/ready pixel-write stream. Define RECT_OUTLINE_EN for outline draws.
module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int COORD_W  = 10,
  parameter int COLOR_W  = 8,
  parameter int ADDR_W   = 19
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_start,
  input  logic               draw_start,
  input  logic [COORD_W-1:0] rect_x0,
  input  logic [COORD_W-1:0] rect_y0,
  input  logic [COORD_W-1:0] rect_x1,
  input  logic [COORD_W-1:0] rect_y1,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
`ifdef RECT_OUTLINE_EN
  input  logic               draw_outline,
`endif
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               draw_done,
  output logic [1:0]         curr_state
);

  state_t             state, next_state;
  rect_t              r;
  logic               accept_clear, accept_draw, load, advance, last, ld_skip;
  logic               ld_xmax_vis, ld_ymax_vis;
  logic [COORD_W-1:0] ld_xmin, ld_xmax, ld_ymin, ld_ymax;
  logic               unused_rect;

  assign r = clip_rect(PKG_COORD_W'(rect_x0), PKG_COORD_W'(rect_y0),
                       PKG_COORD_W'(rect_x1), PKG_COORD_W'(rect_y1),
                       PKG_COORD_W'(SCREEN_W), PKG_COORD_W'(SCREEN_H));
  assign unused_rect = ^r;

  assign accept_clear = (state == IDLE) && clear_start;
  assign accept_draw  = (state == IDLE) && !clear_start && draw_start;
  assign load         = accept_clear || (accept_draw && !r.empty);
  assign advance      = pix_valid && pix_ready && !last;

`ifdef RECT_OUTLINE_EN
  assign ld_skip = accept_draw && draw_outline;
`else
  assign ld_skip = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ld_xmin     = '0;
    ld_xmax     = COORD_W'(SCREEN_W - 1);
    ld_ymin     = '0;
    ld_ymax     = COORD_W'(SCREEN_H - 1);
    ld_xmax_vis = 1'b1;
    ld_ymax_vis = 1'b1;
    if (!accept_clear) begin
      ld_xmin     = r.xmin[COORD_W-1:0];
      ld_xmax     = r.xmax[COORD_W-1:0];
      ld_ymin     = r.ymin[COORD_W-1:0];
      ld_ymax     = r.ymax[COORD_W-1:0];
      ld_xmax_vis = r.xmax_vis;
      ld_ymax_vis = r.ymax_vis;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (clear_start)     next_state = CLEAR;
        else if (draw_start) next_state = r.empty ? DONE : DRAW;
      end
      CLEAR, DRAW: if (pix_ready && last) next_state = DONE;
      DONE:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    pix_valid  = (state == CLEAR) || (state == DRAW);
    busy       = (state == CLEAR) || (state == DRAW);
    draw_done  = (state == DONE);
    curr_state = state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)             pix_color <= '0;
    else if (accept_clear) pix_color <= bg_color;
    else if (accept_draw)  pix_color <= fg_color;
  end

  raster_scan_counter #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .SCREEN_W(SCREEN_W)
  ) u_scan (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (load),
    .ld_xmin    (ld_xmin),
    .ld_xmax    (ld_xmax),
    .ld_ymin    (ld_ymin),
    .ld_ymax    (ld_ymax),
    .ld_skip    (ld_skip),
    .ld_xmax_vis(ld_xmax_vis),
    .ld_ymax_vis(ld_ymax_vis),
    .advance    (advance),
    .x          (DrawX),
    .y          (DrawY),
    .addr       (pix_addr),
    .last       (last)
  );

endmodule
